fmap_streamer: RTL and testbench
================================

# fmap_streamer

Raster-order pixel source for `line_buffer`. On `start`, reads one square feature map from on-chip SRAM at one pixel per cycle with no bubbles. Phase-aligns the stream to `line_buffer`'s free-running column counter, and flags the cycles in which the `line_buffer` outputs complete the last column of a valid 5x5 window. Sits between the feature-map RAM and the line buffer / conv window datapath.

## Interface
Parameters:
- `DATA_WIDTH`, 8, pixel width
- `ADDR_WIDTH`, 12, RAM address width
- `MAX_WIDTH`, 32, largest map width; sizes the column and row counters
- `FEATURE_MAP1_SIZE` … `FEATURE_MAP5_SIZE`, 32/28/14/10/5, width for `mode` 0–4
- `KERNEL_SIZE`, 5, window height and width

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock
- `rst_n`  in  1  async active-low reset, shared with `line_buffer`
- `mode`  in  3  map size select, same encoding as `line_buffer`; 5–7 select `FEATURE_MAP1_SIZE`
- `start`  in  1  frame request; accepted only in IDLE
- `base_addr`  in  `ADDR_WIDTH`  address of pixel (0,0); sampled with `start`
- `busy`  out  1  high from the cycle after acceptance until `done`/`err`
- `done`  out  1  one-cycle pulse at frame end
- `err`  out  1  one-cycle pulse on mode-change abort
- `mem_rd_en`  out  1  RAM read strobe
- `mem_addr`  out  `ADDR_WIDTH`  RAM read address
- `mem_rd_data`  in  `DATA_WIDTH`  RAM data, valid 1 cycle after `mem_rd_en`
- `pix_out`  out  `DATA_WIDTH`  to `line_buffer.data_in`
- `pix_valid`  out  1  `pix_out` carries a frame pixel
- `win_valid`  out  1  aligned with `line_buffer.line_out_*`; window ending at that column is complete

## Operation
- W = width decoded from `mode`. N = W*W pixels, indexed k = r*W + c.
- The shadow column counter free-runs from reset with logic identical to `line_buffer`:
  - reads live `mode`
  - `W-1` → 0, else +1
  - 5-bit wrap if above range
- States:
  - IDLE: `start`=1 → ALIGN; latch `mode` and `base_addr`.
  - ALIGN: when shadow == W-2 (mod W), issue pixel 0 → STREAM.
  - STREAM: issue pixel k each cycle; after k = N-1 → DRAIN.
  - DRAIN: 3 cycles → IDLE with `done`.
- Abort: live `mode` ≠ latched `mode` in ALIGN/STREAM/DRAIN → IDLE next cycle.
  - `err` pulses; `done` is not asserted.
  - `mem_rd_en`, `pix_valid`, `win_valid` drop immediately.
- `start` while `busy` is ignored. `start` in the same cycle as `done`/`err` is ignored.
- `win_valid` for pixel k requires r ≥ KERNEL_SIZE-1 and c ≥ KERNEL_SIZE-1. Count per frame is (W-4)²: 784/576/100/36/1.
- Address arithmetic: `base_addr` + k, modulo 2^`ADDR_WIDTH`.
- `mode` must be held stable while `busy`; `line_buffer` decodes it combinationally.

## Timing
- Pixel k:
  - T_k: `mem_addr` = base+k, `mem_rd_en`=1.
  - T_k+1: RAM data valid.
  - T_k+2: `pix_out` registered, `pix_valid`=1; `line_buffer` column counter = c.
  - T_k+3: `win_valid` registered, coincident with `line_out_*`.
- T_{k+1} = T_k+1; no gaps.
- Start latency: `start` sampled at t. T_0 falls between t+1 and t+W, set by shadow phase.
- `done` and `busy` falling edge: T_{N-1}+4.
- Reset values: `busy`, `done`, `err`, `mem_rd_en`, `pix_valid`, `win_valid` = 0; `mem_addr`, `pix_out` = 0; state IDLE; shadow counter 0.
- Reset mid-frame: immediate return to reset values. `line_buffer` resets on the same `rst_n`, so alignment holds.
- `pix_out` holds its last value when `pix_valid`=0. `line_buffer` still shifts it in; downstream uses `win_valid` only.

## Configuration
- `FMAP_STREAMER_WIN_CNT_EN` defined:
  - adds output `win_count` (`$clog2(MAX_WIDTH*MAX_WIDTH)+1` bits, reset 0)
  - cleared on `start` acceptance, +1 per `win_valid`, held after `done`/`err`
- Undefined: port and counter absent; all other behaviour identical.

## Structure
- Shared package `lenet_fmap_pkg`:
  - mode encodings (`MODE_FM1`…`MODE_FM5`)
  - size constants
  - `width_of_mode()` function, also used by `line_buffer`
  - state enum for IDLE/ALIGN/STREAM/DRAIN
- One sub-module `lb_phase_counter`: the shadow column counter, parameterised like `line_buffer`'s counter so both stay bit-identical.

## Test plan
- `mode`=4, base 0, RAM[a]=a:
  - `pix_out` = 0..24 on consecutive cycles.
  - One `win_valid` pulse; `line_out_0..4` = 4,9,14,19,24 on that cycle.
  - `done` 1 cycle later.
- `mode`=0, base 0x100, RAM[a]=a[7:0]:
  - 784 `win_valid` pulses.
  - First pulse at pixel 132, `line_out_4`=0x84 (RAM[0x184]).
  - `done` at T_1023+4.
- `mode`=3, `start` at each of the 10 shadow phases:
  - Pixel 0 always lands on `line_buffer` column 0.
  - 36 `win_valid` pulses per run.
- `mode` 1→2 at pixel 300 of a `mode`=1 frame:
  - `err` pulse; `busy`=0 next cycle.
  - No `done`; `win_valid` stops.
- `rst_n` low mid-STREAM, then `start` with `mode`=4:
  - All outputs 0 during reset.
  - Clean frame after release.
- `start` pulsed while `busy` → ignored; exactly one `done`.

Source files
------------

// File: rtl/lenet_fmap_pkg.sv
// Shared LeNet feature-map definitions: mode encodings, map sizes,
// the mode-to-width decode used by both line_buffer and fmap_streamer,
// and the streamer state encoding.
package lenet_fmap_pkg;

    localparam logic [2:0] MODE_FM1 = 3'd0;
    localparam logic [2:0] MODE_FM2 = 3'd1;
    localparam logic [2:0] MODE_FM3 = 3'd2;
    localparam logic [2:0] MODE_FM4 = 3'd3;
    localparam logic [2:0] MODE_FM5 = 3'd4;

    localparam int FM1_SIZE = 32;
    localparam int FM2_SIZE = 28;
    localparam int FM3_SIZE = 14;
    localparam int FM4_SIZE = 10;
    localparam int FM5_SIZE = 5;

    // Wide enough to hold the largest width (32) plus headroom for W-1 / W-2.
    localparam int WIDTH_BITS = 7;
    typedef logic [WIDTH_BITS-1:0] width_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ALIGN  = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } fmap_state_e;

    // Unused encodings 5-7 fall back to the largest map, as line_buffer does.
    function automatic width_t width_of_mode(input logic [2:0] mode,
                                             input width_t fm1, input width_t fm2,
                                             input width_t fm3, input width_t fm4,
                                             input width_t fm5);
        width_t w;
        case (mode)
            MODE_FM2: w = fm2;
            MODE_FM3: w = fm3;
            MODE_FM4: w = fm4;
            MODE_FM5: w = fm5;
            default:  w = fm1;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/fmap_streamer_if.sv
// Feature-map RAM read port: registered-read SRAM, data one cycle after rd_en.
interface fmap_streamer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 12
);
    logic                  mem_rd_en;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_rd_data;

    modport master (output mem_rd_en, output mem_addr, input mem_rd_data);
    modport slave  (input mem_rd_en, input mem_addr, output mem_rd_data);
endinterface

// File: rtl/lb_phase_counter.sv
// Shadow copy of line_buffer's free-running column counter. It must stay
// bit-identical to the line_buffer counter: same reset, same live-mode decode,
// same wrap rule (W-1 -> 0, otherwise +1 with natural wrap when out of range).
module lb_phase_counter import lenet_fmap_pkg::*; #(
    parameter int MAX_WIDTH         = 32,
    parameter int FEATURE_MAP1_SIZE = FM1_SIZE,
    parameter int FEATURE_MAP2_SIZE = FM2_SIZE,
    parameter int FEATURE_MAP3_SIZE = FM3_SIZE,
    parameter int FEATURE_MAP4_SIZE = FM4_SIZE,
    parameter int FEATURE_MAP5_SIZE = FM5_SIZE,
    localparam int COL_BITS         = $clog2(MAX_WIDTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [2:0]          mode,
    output logic [COL_BITS-1:0] col
);

    width_t w_m1;

    assign w_m1 = width_of_mode(mode,
                                width_t'(FEATURE_MAP1_SIZE), width_t'(FEATURE_MAP2_SIZE),
                                width_t'(FEATURE_MAP3_SIZE), width_t'(FEATURE_MAP4_SIZE),
                                width_t'(FEATURE_MAP5_SIZE)) - width_t'(1);

    // Free-running column count, restarting at the end of each row of the live map width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            col <= '0;
        else if (width_t'(col) == w_m1)
            col <= '0;
        else
            col <= col + COL_BITS'(1);
    end

endmodule

// File: rtl/fmap_streamer.sv
// Raster-order feature-map source for line_buffer. Reads one square map from
// SRAM at one pixel per cycle, phase-aligned so pixel 0 lands on line_buffer
// column 0, and flags the cycles where the line_buffer outputs complete a 5x5
// window. Optional macro FMAP_STREAMER_WIN_CNT_EN adds a per-frame window counter.
module fmap_streamer import lenet_fmap_pkg::*; #(
    parameter int DATA_WIDTH        = 8,
    parameter int ADDR_WIDTH        = 12,
    parameter int MAX_WIDTH         = 32,
    parameter int FEATURE_MAP1_SIZE = FM1_SIZE,
    parameter int FEATURE_MAP2_SIZE = FM2_SIZE,
    parameter int FEATURE_MAP3_SIZE = FM3_SIZE,
    parameter int FEATURE_MAP4_SIZE = FM4_SIZE,
    parameter int FEATURE_MAP5_SIZE = FM5_SIZE,
    parameter int KERNEL_SIZE       = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            mode,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    fmap_streamer_if.master       mem,
    output logic [DATA_WIDTH-1:0] pix_out,
    output logic                  pix_valid,
    output logic                  win_valid
`ifdef FMAP_STREAMER_WIN_CNT_EN
    ,
    output logic [$clog2(MAX_WIDTH*MAX_WIDTH):0] win_count
`endif
);

    localparam int COL_BITS = $clog2(MAX_WIDTH);

    fmap_state_e           state;
    logic [2:0]            mode_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [COL_BITS-1:0]   shadow;
    logic [COL_BITS-1:0]   iss_col;
    logic [COL_BITS-1:0]   iss_row;
    logic [1:0]            drain_cnt;
    width_t                w_q;
    logic                  active;
    logic                  mismatch;
    logic                  accept;
    logic                  issue;
    logic                  last_pix;
    logic                  win_cond;
    logic                  rd_v1;
    logic                  win_q0;
    logic                  win_q1;
    logic                  pv_q;
    logic                  wv_q;

    lb_phase_counter #(
        .MAX_WIDTH         (MAX_WIDTH),
        .FEATURE_MAP1_SIZE (FEATURE_MAP1_SIZE),
        .FEATURE_MAP2_SIZE (FEATURE_MAP2_SIZE),
        .FEATURE_MAP3_SIZE (FEATURE_MAP3_SIZE),
        .FEATURE_MAP4_SIZE (FEATURE_MAP4_SIZE),
        .FEATURE_MAP5_SIZE (FEATURE_MAP5_SIZE)
    ) u_phase (
        .clk   (clk),
        .rst_n (rst_n),
        .mode  (mode),
        .col   (shadow)
    );

    assign w_q = width_of_mode(mode_q,
                               width_t'(FEATURE_MAP1_SIZE), width_t'(FEATURE_MAP2_SIZE),
                               width_t'(FEATURE_MAP3_SIZE), width_t'(FEATURE_MAP4_SIZE),
                               width_t'(FEATURE_MAP5_SIZE));

    assign active   = (state != ST_IDLE);
    assign mismatch = active && (mode != mode_q);
    assign accept   = (state == ST_IDLE) && start && !done && !err;
    assign last_pix = (width_t'(iss_row) == w_q - width_t'(1)) &&
                      (width_t'(iss_col) == w_q - width_t'(1));
    assign win_cond = (width_t'(iss_row) >= width_t'(KERNEL_SIZE - 1)) &&
                      (width_t'(iss_col) >= width_t'(KERNEL_SIZE - 1));

    // A pixel is read when the shadow column is two ahead of column 0 (RAM plus
    // pix_out register latency), then every cycle of STREAM; a mode change kills it at once.
    always_comb begin
        issue = 1'b0;
        case (state)
            ST_ALIGN:  issue = (width_t'(shadow) == w_q - width_t'(2));
            ST_STREAM: issue = 1'b1;
            default:   issue = 1'b0;
        endcase
        if (mismatch)
            issue = 1'b0;
    end

    assign mem.mem_rd_en = issue;
    assign mem.mem_addr  = addr_q;
    assign busy          = active;
    assign pix_valid     = pv_q && !mismatch;
    assign win_valid     = wv_q && !mismatch;

    // Frame sequencing, read address and raster position of the pixel being read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_FM1;
            addr_q    <= '0;
            iss_col   <= '0;
            iss_row   <= '0;
            drain_cnt <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            if (mismatch) begin
                state <= ST_IDLE;
                err   <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (accept) begin
                            state   <= ST_ALIGN;
                            mode_q  <= mode;
                            addr_q  <= base_addr;
                            iss_col <= '0;
                            iss_row <= '0;
                        end
                    end
                    ST_ALIGN: begin
                        if (issue)
                            state <= ST_STREAM;
                    end
                    ST_STREAM: begin
                        if (last_pix) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= '0;
                        end
                    end
                    default: begin
                        if (drain_cnt == 2'd2) begin
                            state <= ST_IDLE;
                            done  <= 1'b1;
                        end else begin
                            drain_cnt <= drain_cnt + 2'd1;
                        end
                    end
                endcase
            end
            if (issue) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                if (width_t'(iss_col) == w_q - width_t'(1)) begin
                    iss_col <= '0;
                    iss_row <= iss_row + COL_BITS'(1);
                end else begin
                    iss_col <= iss_col + COL_BITS'(1);
                end
            end
        end
    end

    // Delay line matching RAM latency, the pix_out register and line_buffer's output stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_v1   <= 1'b0;
            win_q0  <= 1'b0;
            win_q1  <= 1'b0;
            pv_q    <= 1'b0;
            wv_q    <= 1'b0;
            pix_out <= '0;
        end else if (mismatch) begin
            rd_v1  <= 1'b0;
            win_q0 <= 1'b0;
            win_q1 <= 1'b0;
            pv_q   <= 1'b0;
            wv_q   <= 1'b0;
        end else begin
            rd_v1  <= issue;
            win_q0 <= issue && win_cond;
            win_q1 <= win_q0;
            pv_q   <= rd_v1;
            wv_q   <= win_q1;
            if (rd_v1)
                pix_out <= mem.mem_rd_data;
        end
    end

`ifdef FMAP_STREAMER_WIN_CNT_EN
    // Windows produced in the current or most recent frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            win_count <= '0;
        else if (accept)
            win_count <= '0;
        else if (win_valid)
            win_count <= win_count + 1'b1;
    end
`endif

endmodule

// File: tb/tb_fmap_streamer.sv
// Directed bench for fmap_streamer with a registered-read RAM model
// (RAM[a] = a[7:0]) and a model of line_buffer's column counter.
`timescale 1ns/1ps
module tb_fmap_streamer;

    logic        clk;
    logic        rst_n;
    logic [2:0]  mode;
    logic        start;
    logic [11:0] base_addr;
    logic        busy, done, err;
    logic [7:0]  pix_out;
    logic        pix_valid, win_valid;
`ifdef FMAP_STREAMER_WIN_CNT_EN
    logic [10:0] win_count;
`endif

    fmap_streamer_if #(.DATA_WIDTH(8), .ADDR_WIDTH(12)) mem_if ();

    fmap_streamer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .start     (start),
        .base_addr (base_addr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .mem       (mem_if),
        .pix_out   (pix_out),
        .pix_valid (pix_valid),
        .win_valid (win_valid)
`ifdef FMAP_STREAMER_WIN_CNT_EN
        ,
        .win_count (win_count)
`endif
    );

    int vec_cnt = 0;
    int miss_cnt = 0;

    // stimulus-owned
    bit mon_clr = 0;
    int exp_w = 5;
    int exp_base = 0;
    int chg_cyc = 1 << 30;

    // monitor-owned
    int cyc = 0;
    int pix_idx, rd_idx, win_cnt, done_cnt, err_cnt;
    int pix_bad, addr_bad, gap_bad, phase_bad, win_bad, post_act;
    int first_rd_cyc, last_rd_cyc, last_win_cyc, done_cyc, err_cyc, start_cyc, first_win_k;
    bit started, prev_pv, prev_rst, done_busy, err_busy, busy_after;
    logic [2:0] prev_mode = 3'd0;
    logic [4:0] lb_col = 5'd0;
    logic [7:0] hist [1024];
    logic [7:0] lo [5];

    function automatic int w_of(input logic [2:0] m);
        case (m)
            3'd1: return 28;
            3'd2: return 14;
            3'd3: return 10;
            3'd4: return 5;
            default: return 32;
        endcase
    endfunction

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        if (mem_if.mem_rd_en)
            mem_if.mem_rd_data <= mem_if.mem_addr[7:0];
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    // Monitor: samples at negedge, models line_buffer column, gathers per-frame stats.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (!rst_n || !prev_rst) lb_col = 5'd0;
        else if (int'(lb_col) == w_of(prev_mode) - 1) lb_col = 5'd0;
        else lb_col = lb_col + 5'd1;
        if (mon_clr) begin
            pix_idx = 0; rd_idx = 0; win_cnt = 0; done_cnt = 0; err_cnt = 0;
            pix_bad = 0; addr_bad = 0; gap_bad = 0; phase_bad = 0; win_bad = 0; post_act = 0;
            first_rd_cyc = -1; last_rd_cyc = -1; last_win_cyc = -1; done_cyc = -1; err_cyc = -1;
            start_cyc = -1; first_win_k = -1; started = 0; prev_pv = 0;
            done_busy = 0; err_busy = 0; busy_after = 0;
            for (int i = 0; i < 5; i++) lo[i] = 8'h00;
        end else begin
            if (start && !started) begin started = 1; start_cyc = cyc; end
            if (started && cyc == start_cyc + 1) busy_after = busy;
            if (mem_if.mem_rd_en) begin
                if (rd_idx == 0) first_rd_cyc = cyc;
                if (mem_if.mem_addr !== 12'(exp_base + rd_idx)) addr_bad++;
                last_rd_cyc = cyc;
                rd_idx++;
            end
            if (win_valid) begin
                int kp;
                kp = pix_idx - 1;
                if (!prev_pv || kp < 0) win_bad++;
                else if ((kp / exp_w) < 4 || (kp % exp_w) < 4) win_bad++;
                if (win_cnt == 0 && kp >= 0) begin
                    first_win_k = kp;
                    for (int i = 0; i < 5; i++) begin
                        int idx;
                        idx = kp - (4 - i) * exp_w;
                        lo[i] = (idx >= 0) ? hist[idx] : 8'h00;
                    end
                end
                win_cnt++;
                last_win_cyc = cyc;
            end
            if (pix_valid) begin
                if (pix_idx == 0 && lb_col != 5'd0) phase_bad++;
                if (pix_idx > 0 && !prev_pv) gap_bad++;
                if (pix_out !== 8'(exp_base + pix_idx)) pix_bad++;
                if (pix_idx < 1024) hist[pix_idx] = pix_out;
                pix_idx++;
            end
            prev_pv = pix_valid;
            if (cyc >= chg_cyc && (mem_if.mem_rd_en || pix_valid || win_valid)) post_act++;
            if (done) begin done_cnt++; done_cyc = cyc; done_busy = busy; end
            if (err) begin err_cnt++; err_cyc = cyc; err_busy = busy; end
        end
        prev_rst = rst_n;
        prev_mode = mode;
    end

    task automatic start_frame(input logic [2:0] m, input logic [11:0] b);
        @(posedge clk); #2;
        mon_clr = 1; mode = m; base_addr = b;
        exp_w = w_of(m); exp_base = int'(b);
        @(posedge clk); #2;
        mon_clr = 0; start = 1;
        @(posedge clk); #2;
        start = 0;
    endtask

    task automatic wait_end(input int budget, output bit to);
        to = 1;
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            if (done_cnt > 0 || err_cnt > 0) begin to = 0; break; end
        end
        repeat (3) @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 0; start = 0; mode = 3'd0; base_addr = 12'h000;
        repeat (3) @(posedge clk);
        #3;
        vec_cnt++; if (busy !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        vec_cnt++; if (done !== 1'b0 || err !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_done_err: got %b%b expected 00", done, err); end
        vec_cnt++; if (mem_if.mem_rd_en !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_rd_en: got %b expected 0", mem_if.mem_rd_en); end
        vec_cnt++; if (mem_if.mem_addr !== 12'h000) begin miss_cnt++; $display("[TB] FAIL rst_addr: got %h expected 000", mem_if.mem_addr); end
        vec_cnt++; if (pix_out !== 8'h00 || pix_valid !== 1'b0 || win_valid !== 1'b0) begin miss_cnt++; $display("[TB] FAIL rst_pix: got %h %b %b expected 00 0 0", pix_out, pix_valid, win_valid); end
        @(posedge clk); #2;
        rst_n = 1;
    endtask

    task automatic test_mode4();
        bit to;
        start_frame(3'd4, 12'h000);
        wait_end(200, to);
        vec_cnt++; if (to !== 1'b0) begin miss_cnt++; $display("[TB] FAIL m4_timeout: got %b expected 0", to); end
        vec_cnt++; if (busy_after !== 1'b1) begin miss_cnt++; $display("[TB] FAIL m4_busy_after_start: got %b expected 1", busy_after); end
        vec_cnt++; if (first_rd_cyc - start_cyc < 1 || first_rd_cyc - start_cyc > 5) begin miss_cnt++; $display("[TB] FAIL m4_latency: got %0d expected 1..5", first_rd_cyc - start_cyc); end
        vec_cnt++; if (pix_idx !== 25 || pix_bad !== 0 || gap_bad !== 0) begin miss_cnt++; $display("[TB] FAIL m4_pixels: got %0d pix %0d bad %0d gaps expected 25 0 0", pix_idx, pix_bad, gap_bad); end
        vec_cnt++; if (phase_bad !== 0) begin miss_cnt++; $display("[TB] FAIL m4_phase: got %0d expected 0", phase_bad); end
        vec_cnt++; if (addr_bad !== 0 || rd_idx !== 25) begin miss_cnt++; $display("[TB] FAIL m4_addr: got %0d bad %0d reads expected 0 25", addr_bad, rd_idx); end
        vec_cnt++; if (win_cnt !== 1 || win_bad !== 0) begin miss_cnt++; $display("[TB] FAIL m4_win: got %0d wins %0d bad expected 1 0", win_cnt, win_bad); end
        for (int i = 0; i < 5; i++) begin
            vec_cnt++; if (lo[i] !== 8'(5 * i + 4)) begin miss_cnt++; $display("[TB] FAIL m4_line_out_%0d: got %0d expected %0d", i, lo[i], 5 * i + 4); end
        end
        vec_cnt++; if (done_cnt !== 1 || done_cyc !== last_win_cyc + 1) begin miss_cnt++; $display("[TB] FAIL m4_done: got %0d at %0d expected 1 at %0d", done_cnt, done_cyc, last_win_cyc + 1); end
        vec_cnt++; if (done_cyc !== last_rd_cyc + 4 || done_busy !== 1'b0) begin miss_cnt++; $display("[TB] FAIL m4_done_time: got %0d busy %b expected %0d busy 0", done_cyc, done_busy, last_rd_cyc + 4); end
    endtask

    task automatic test_mode0();
        bit to;
        start_frame(3'd0, 12'h100);
        wait_end(1200, to);
        vec_cnt++; if (to !== 1'b0) begin miss_cnt++; $display("[TB] FAIL m0_timeout: got %b expected 0", to); end
        vec_cnt++; if (pix_idx !== 1024 || pix_bad !== 0 || gap_bad !== 0) begin miss_cnt++; $display("[TB] FAIL m0_pixels: got %0d pix %0d bad %0d gaps expected 1024 0 0", pix_idx, pix_bad, gap_bad); end
        vec_cnt++; if (addr_bad !== 0 || phase_bad !== 0) begin miss_cnt++; $display("[TB] FAIL m0_addr_phase: got %0d %0d expected 0 0", addr_bad, phase_bad); end
        vec_cnt++; if (win_cnt !== 784 || win_bad !== 0) begin miss_cnt++; $display("[TB] FAIL m0_win: got %0d wins %0d bad expected 784 0", win_cnt, win_bad); end
        vec_cnt++; if (first_win_k !== 132 || lo[4] !== 8'h84) begin miss_cnt++; $display("[TB] FAIL m0_first_win: got k=%0d lo4=%h expected k=132 lo4=84", first_win_k, lo[4]); end
        vec_cnt++; if (done_cnt !== 1 || done_cyc !== last_rd_cyc + 4) begin miss_cnt++; $display("[TB] FAIL m0_done: got %0d at %0d expected 1 at %0d", done_cnt, done_cyc, last_rd_cyc + 4); end
    endtask

    task automatic test_addr_wrap();
        bit to;
        start_frame(3'd4, 12'hFF0);
        wait_end(200, to);
        vec_cnt++; if (to !== 1'b0 || done_cnt !== 1) begin miss_cnt++; $display("[TB] FAIL wrap_done: got to=%b done=%0d expected 0 1", to, done_cnt); end
        vec_cnt++; if (addr_bad !== 0 || pix_bad !== 0) begin miss_cnt++; $display("[TB] FAIL wrap_addr: got %0d addr %0d pix bad expected 0 0", addr_bad, pix_bad); end
    endtask

    task automatic test_phases();
        bit to;
        for (int p = 0; p < 10; p++) begin
            @(posedge clk); #2;
            mon_clr = 1; mode = 3'd3; base_addr = 12'h020; exp_w = 10; exp_base = 32'h020;
            for (int i = 0; i < 40; i++) begin
                @(posedge clk);
                if (int'(lb_col) == p) break;
            end
            #2;
            mon_clr = 0; start = 1;
            @(posedge clk); #2;
            start = 0;
            wait_end(300, to);
            vec_cnt++; if (to !== 1'b0 || done_cnt !== 1) begin miss_cnt++; $display("[TB] FAIL ph%0d_done: got to=%b done=%0d expected 0 1", p, to, done_cnt); end
            vec_cnt++; if (phase_bad !== 0 || pix_idx !== 100 || pix_bad !== 0) begin miss_cnt++; $display("[TB] FAIL ph%0d_align: got %0d phase %0d pix %0d bad expected 0 100 0", p, phase_bad, pix_idx, pix_bad); end
            vec_cnt++; if (win_cnt !== 36 || win_bad !== 0) begin miss_cnt++; $display("[TB] FAIL ph%0d_win: got %0d wins %0d bad expected 36 0", p, win_cnt, win_bad); end
            vec_cnt++; if (first_rd_cyc - start_cyc < 1 || first_rd_cyc - start_cyc > 10) begin miss_cnt++; $display("[TB] FAIL ph%0d_latency: got %0d expected 1..10", p, first_rd_cyc - start_cyc); end
        end
    endtask

    task automatic test_abort();
        bit to;
        int i;
        start_frame(3'd1, 12'h000);
        for (i = 0; i < 1000; i++) begin
            @(posedge clk);
            if (pix_idx >= 300) break;
        end
        #2;
        mode = 3'd2;
        chg_cyc = cyc + 1;
        wait_end(50, to);
        vec_cnt++; if (to !== 1'b0 || err_cnt !== 1) begin miss_cnt++; $display("[TB] FAIL abort_err: got to=%b err=%0d expected 0 1", to, err_cnt); end
        vec_cnt++; if (err_cyc !== chg_cyc + 1 || err_busy !== 1'b0) begin miss_cnt++; $display("[TB] FAIL abort_err_time: got %0d busy %b expected %0d busy 0", err_cyc, err_busy, chg_cyc + 1); end
        vec_cnt++; if (done_cnt !== 0) begin miss_cnt++; $display("[TB] FAIL abort_no_done: got %0d expected 0", done_cnt); end
        vec_cnt++; if (post_act !== 0 || win_cnt >= 576) begin miss_cnt++; $display("[TB] FAIL abort_quiet: got %0d active cycles %0d wins expected 0 <576", post_act, win_cnt); end
        chg_cyc = 1 << 30;
    endtask

    task automatic test_reset_mid();
        bit to;
        int i;
        start_frame(3'd0, 12'h000);
        for (i = 0; i < 500; i++) begin
            @(posedge clk);
            if (pix_idx >= 50) break;
        end
        #2;
        rst_n = 0;
        #1;
        vec_cnt++; if (busy !== 1'b0 || mem_if.mem_rd_en !== 1'b0 || mem_if.mem_addr !== 12'h000) begin miss_cnt++; $display("[TB] FAIL midrst_ctrl: got %b %b %h expected 0 0 000", busy, mem_if.mem_rd_en, mem_if.mem_addr); end
        vec_cnt++; if (pix_out !== 8'h00 || pix_valid !== 1'b0 || win_valid !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin miss_cnt++; $display("[TB] FAIL midrst_out: got %h %b %b %b %b expected 00 0 0 0 0", pix_out, pix_valid, win_valid, done, err); end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1;
        start_frame(3'd4, 12'h000);
        wait_end(200, to);
        vec_cnt++; if (to !== 1'b0 || done_cnt !== 1 || err_cnt !== 0) begin miss_cnt++; $display("[TB] FAIL midrst_frame: got to=%b done=%0d err=%0d expected 0 1 0", to, done_cnt, err_cnt); end
        vec_cnt++; if (pix_idx !== 25 || pix_bad !== 0 || phase_bad !== 0 || win_cnt !== 1) begin miss_cnt++; $display("[TB] FAIL midrst_stream: got %0d pix %0d bad %0d phase %0d wins expected 25 0 0 1", pix_idx, pix_bad, phase_bad, win_cnt); end
    endtask

    task automatic test_back_to_back();
        int i;
        start_frame(3'd4, 12'h040);
        repeat (4) @(posedge clk);
        #2; start = 1;
        @(posedge clk); #2; start = 0;
        for (i = 0; i < 200; i++) begin
            @(posedge clk);
            if (win_cnt >= 1) break;
        end
        #2; start = 1;
        @(posedge clk); #2; start = 0;
        repeat (60) @(posedge clk);
        #2;
        vec_cnt++; if (done_cnt !== 1) begin miss_cnt++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", done_cnt); end
        vec_cnt++; if (busy !== 1'b0 || pix_idx !== 25 || pix_bad !== 0) begin miss_cnt++; $display("[TB] FAIL b2b_single_frame: got busy=%b pix=%0d bad=%0d expected 0 25 0", busy, pix_idx, pix_bad); end
    endtask

    initial begin
        test_reset();
        test_mode4();
        test_mode0();
        test_addr_wrap();
        test_phases();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
